uart_tx: RTL and testbench

UART transmitter with an integrated write-side FIFO. It serialises DATA_WIDTH-bit words as 8N1-style frames (start, data LSB-first, stop) on a single line, at CLK_FREQ/BAUD_RATE clocks per bit. It is the transmit counterpart of the project's UART receiver; the two share the baud and frame parameters so a tx_bit_o to rx_bit_i loopback is lossless. The host pushes words into the FIFO; the transmit FSM drains the FIFO autonomously while enabled.

---
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_tx.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: host write port of the UART transmitter FIFO.
// Signals: tx_wen_i/din_i write strobe and data; full_o/empty_o FIFO status.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_wen_i;
  logic [DATA_WIDTH-1:0] din_i;
  logic                  full_o;
  logic                  empty_o;

  modport master (
    output tx_wen_i,
    output din_i,
    input  full_o,
    input  empty_o
  );

  modport slave (
    input  tx_wen_i,
    input  din_i,
    output full_o,
    output empty_o
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, start/data LSB-first/stop frames.
// Ports: clk_i, rst_ni (sync, active low), tx_en_i frame-start enable,
//   bus (uart_tx_if.slave: tx_wen_i, din_i, full_o, empty_o),
//   tx_bit_o serial line (idle high), busy_o FSM not idle.
// Optional: define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     tx_en_i,
  uart_tx_if.slave bus,
  output logic     tx_bit_o,
  output logic     busy_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW  = $clog2(BAUD_DIV);
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;

  state_t                r_state;
  state_t                w_state_n;
  logic [BW-1:0]         r_baud;
  logic [BW-1:0]         w_baud_n;
  logic [BCW-1:0]        r_bitc;
  logic [BCW-1:0]        w_bitc_n;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_n;
  logic                  r_tx;
  logic                  w_tx_n;
`ifdef UART_TX_PARITY_EN
  logic                  r_par;
  logic                  w_par_n;
`endif

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_go;
  logic                  w_bit_end;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_wr      = bus.tx_wen_i & ~w_full;
  assign w_go      = tx_en_i & ~w_empty;
  assign w_bit_end = (r_baud == BW'(BAUD_DIV - 1));
  assign w_last    = (r_bitc == BCW'(DATA_WIDTH - 1));
  assign w_head    = r_mem[r_rptr];

  assign bus.full_o  = w_full;
  assign bus.empty_o = w_empty;
  assign tx_bit_o    = r_tx;
  assign busy_o      = (r_state != S_IDLE);

  // FIFO storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= bus.din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bitc  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_pop) r_cnt <= r_cnt - 1'b1;
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bitc  <= w_bitc_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (w_go) w_state_n = S_START;
      S_START: if (w_bit_end) w_state_n = S_DATA;
      S_DATA: begin
        if (w_bit_end && w_last) begin
`ifdef UART_TX_PARITY_EN
          w_state_n = S_PAR;
`else
          w_state_n = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR:   if (w_bit_end) w_state_n = S_STOP;
`endif
      S_STOP: begin
        if (w_bit_end) w_state_n = w_go ? S_START : S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_tx_n    = r_tx;
    w_shift_n = r_shift;
    w_bitc_n  = r_bitc;
    w_baud_n  = '0;
`ifdef UART_TX_PARITY_EN
    w_par_n   = r_par;
`endif
    if (r_state != S_IDLE && !w_bit_end) w_baud_n = r_baud + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        if (w_go) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_bitc_n  = '0;
          w_tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_par_n   = ^w_head;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) w_tx_n = r_shift[0];
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_n = r_shift >> 1;
          w_bitc_n  = r_bitc + 1'b1;
`ifdef UART_TX_PARITY_EN
          w_tx_n    = w_last ? r_par : w_shift_n[0];
`else
          w_tx_n    = w_last ? 1'b1 : w_shift_n[0];
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        if (w_bit_end) w_tx_n = 1'b1;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_tx_n = 1'b1;
          // Back-to-back frame: reload straight from the FIFO head.
          if (w_go) begin
            w_pop     = 1'b1;
            w_shift_n = w_head;
            w_bitc_n  = '0;
            w_tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_par_n   = ^w_head;
`endif
          end
        end
      end
      default: w_tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
// BAUD_DIV = 10; frames are checked cycle by cycle on tx_bit_o.
module tb_uart_tx;

  localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic tx_en;
  logic tx_bit;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .DATA_WIDTH(8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .tx_en_i (tx_en),
    .bus     (bus),
    .tx_bit_o(tx_bit),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    bus.tx_wen_i = 1'b1;
    bus.din_i    = d;
    tick();
    bus.tx_wen_i = 1'b0;
  endtask

  // Entered on the first cycle of the start bit; leaves one cycle
  // after the stop bit ends.
  task automatic frame(input logic [7:0] v, input string tag);
    logic [10:0] e;
    logic [7:0]  rx;
    logic        ok;
    rx = '0;
`ifdef UART_TX_PARITY_EN
    e = {1'b1, ^v, v, 1'b0};
`else
    e = {1'b1, 1'b1, v, 1'b0};
`endif
    for (int b = 0; b < NB; b++) begin
      ok = 1'b1;
      for (int c = 0; c < BD; c++) begin
        if (tx_bit !== e[b] || busy !== 1'b1) ok = 1'b0;
        if (c == BD / 2 && b >= 1 && b <= 8) rx[b-1] = tx_bit;
        tick();
      end
      chk($sformatf("%s bit%0d", tag, b), {31'd0, ok}, 32'd1);
    end
    chk({tag, " rx"}, {24'd0, rx}, {24'd0, v});
  endtask

  initial begin
    rst_n        = 1'b0;
    tx_en        = 1'b0;
    bus.tx_wen_i = 1'b0;
    bus.din_i    = '0;

    // 1: reset
    repeat (3) tick();
    chk("rst tx", {31'd0, tx_bit}, 32'd1);
    chk("rst empty", {31'd0, bus.empty_o}, 32'd1);
    chk("rst full", {31'd0, bus.full_o}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 2: single frame with latency
    tx_en = 1'b1;
    wr(8'hA5);
    chk("lat empty", {31'd0, bus.empty_o}, 32'd0);
    chk("lat tx", {31'd0, tx_bit}, 32'd1);
    chk("lat busy", {31'd0, busy}, 32'd0);
    tick();
    frame(8'hA5, "a5");
    chk("a5 busy end", {31'd0, busy}, 32'd0);
    chk("a5 tx end", {31'd0, tx_bit}, 32'd1);
    chk("a5 empty end", {31'd0, bus.empty_o}, 32'd1);

    // 3: back-to-back
    tx_en = 1'b0;
    wr(8'h00);
    wr(8'hFF);
    wr(8'h3C);
    tx_en = 1'b1;
    tick();
    frame(8'h00, "b0");
    frame(8'hFF, "b1");
    chk("b2 empty", {31'd0, bus.empty_o}, 32'd1);
    frame(8'h3C, "b2");
    chk("b busy end", {31'd0, busy}, 32'd0);

    // 4: fill and overflow
    tx_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr(8'(i));
      if (i == 14) chk("full@15", {31'd0, bus.full_o}, 32'd0);
      if (i == 15) chk("full@16", {31'd0, bus.full_o}, 32'd1);
      if (i == 16) chk("full@17", {31'd0, bus.full_o}, 32'd1);
    end
    tx_en = 1'b1;
    tick();
    chk("full after pop", {31'd0, bus.full_o}, 32'd0);
    for (int k = 0; k < 16; k++) frame(8'(k), $sformatf("f%0d", k));
    chk("ovf busy end", {31'd0, busy}, 32'd0);
    chk("ovf empty end", {31'd0, bus.empty_o}, 32'd1);

    // 5: enable drop mid-frame, then reset mid-frame
    tx_en = 1'b0;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    frame(8'h11, "en1");
    chk("hold busy", {31'd0, busy}, 32'd0);
    chk("hold empty", {31'd0, bus.empty_o}, 32'd0);
    repeat (5) tick();
    chk("hold tx", {31'd0, tx_bit}, 32'd1);
    chk("hold busy2", {31'd0, busy}, 32'd0);
    tx_en = 1'b1;
    tick();
    chk("resume tx", {31'd0, tx_bit}, 32'd0);
    chk("resume busy", {31'd0, busy}, 32'd1);
    repeat (35) tick();
    chk("mid bit2", {31'd0, tx_bit}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("abort tx", {31'd0, tx_bit}, 32'd1);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort empty", {31'd0, bus.empty_o}, 32'd1);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post tx", {31'd0, tx_bit}, 32'd1);
    chk("post busy", {31'd0, busy}, 32'd0);

`ifdef UART_TX_PARITY_EN
    // 6: parity frames
    tx_en = 1'b0;
    wr(8'h07);
    wr(8'h03);
    tx_en = 1'b1;
    tick();
    frame(8'h07, "p07");
    frame(8'h03, "p03");
    chk("par busy end", {31'd0, busy}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
